ama_riscv_imem_loader: RTL and testbench
========================================

Name: ama_riscv_imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream from the UART RX path and assembles little-endian 32-bit words.
- Drives the IMEM write port (wea/addra/dina), so new programs are loaded at runtime with no re-synthesis.
- Asserts load_active while a frame is in progress, so the top level can hold the core in reset.

Parameters:
- ADDR_W, 14: IMEM word-address width. Depth DEPTH = 2**ADDR_W words; ADDR_W <= 15.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes inside a frame before the frame is aborted. 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte. A byte transfers on rx_valid && rx_ready.
- wea  output  1  IMEM write enable, single-cycle pulse.
- addra  output  ADDR_W  IMEM word address.
- dina  output  32  IMEM write data.
- load_active  output  1  frame in progress.
- load_done  output  1  1-cycle pulse: frame completed, checksum OK.
- load_err  output  1  1-cycle pulse: frame aborted.
- err_code  output  2  00 none, 01 range, 10 checksum, 11 timeout.

Behaviour:
- Reset (async, immediate):
  - All outputs 0, including rx_ready.
  - State IDLE; word address, byte index, checksum and timeout counter cleared.
  - Reset mid-frame abandons the frame. Words already written stay in IMEM.
- Frame format:
  - A0, A1: start address = {A1, A0}[ADDR_W-1:0]. Upper bits are ignored.
  - C0, C1: word count N = {C1, C0}.
  - 4*N data bytes, least-significant byte first within each word.
  - S: checksum byte = 8-bit sum, modulo 256, of the data bytes only.
- States: IDLE, HDR, DATA, CSUM, RESP.
  - IDLE, rx_ready=1. Accepting A0: clear err_code, set load_active=1, go to HDR.
  - HDR, rx_ready=1. Collects A1, C0, C1. After C1:
    - start + N > DEPTH, or N > DEPTH: go to RESP with err 01.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA, rx_ready=1.
    - Shift each byte into a 32-bit assembly register; 2-bit byte index; accumulate checksum.
    - On the 4th byte of a word: in the next cycle wea=1, addra = current address, dina = assembled word. The address then increments.
    - After word N goes to CSUM. The S byte may arrive in the same cycle as the final wea.
  - CSUM, rx_ready=1. Accept S; go to RESP with match (done) or err 10.
  - RESP, rx_ready=0, one cycle:
    - Match: load_done=1.
    - Error: load_err=1 and err_code updated.
    - load_active drops in this same cycle. Next state IDLE.
- Timeout: in HDR, DATA and CSUM a counter increments each cycle with no accepted byte and clears on each accepted byte. Reaching TIMEOUT_CYCLES sends the FSM to RESP with err 11.
- wea is never asserted in IDLE, HDR or RESP, except the final word's write pulse, which may land in CSUM.
- err_code holds its value until the next A0 is accepted.
- Address arithmetic uses ADDR_W+1 bits, so the end-of-memory case (start + N == DEPTH) is legal and does not wrap.

Test Plan:
- Reset, then frame 10 00 02 00 | 13 00 00 00 | EF BE AD DE | 4B:
  - wea@0x010 with dina 0x00000013, then wea@0x011 with dina 0xDEADBEEF.
  - load_done pulse; err_code 00; load_active high from A0 until the done cycle.
- Same frame with S=4C: both writes occur, then load_err with err_code 10; rx_ready low for exactly one cycle.
- Range boundary:
  - Header FF 3F 02 00: err 01 right after C1, no wea.
  - Header FF 3F 01 00 + word + correct S: write to 0x3FFF, load_done.
- Empty frame 00 00 00 00 00: load_done, no wea.
  - Follow with 00 00 00 00 01: err 10.
- TIMEOUT_CYCLES=16: send header with N=1 plus 2 data bytes, then stall 16 cycles.
  - Required: err 11, FSM back in IDLE.
  - A following valid frame completes normally and err_code clears on its A0.
- Assert rst mid-DATA with rx_valid held high:
  - wea, rx_ready and load_active go 0 immediately.
  - After release, a full valid frame loads correctly.

Source files
------------

// File: rtl/ama_riscv_imem_loader.sv
// ama_riscv_imem_loader
// Writer side of the instruction memory. It takes a framed byte stream from
// the UART RX path, builds little-endian 32-bit words from it and writes them
// through the IMEM write port. Programs can then be loaded at runtime.
//
// Frame: A0 A1 | C0 C1 | 4*N data bytes (LSB first per word) | S
//   start address = {A1,A0}[ADDR_W-1:0], word count N = {C1,C0},
//   S = sum of the data bytes, modulo 256.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   rx_data       incoming byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte (registered, 0 in reset and in RESP)
//   wea           IMEM write enable, one-cycle pulse
//   addra         IMEM word address
//   dina          IMEM write data
//   load_active   frame in progress (top level holds the core in reset)
//   load_done     one-cycle pulse: frame complete, checksum matched
//   load_err      one-cycle pulse: frame aborted
//   err_code      00 none, 01 range, 10 checksum, 11 timeout; holds until next A0
//   dbg_state     current FSM state (debug visibility only)
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready
// are both high. The sender keeps rx_data stable while rx_valid is high and
// may not withdraw a byte before it is accepted; rx_ready does not depend on
// rx_valid in the same cycle.
module ama_riscv_imem_loader #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              load_active,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam int          DEPTH   = 2**ADDR_W;
  localparam logic [16:0] DEPTH_X = 17'(DEPTH);
  localparam int          TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state;
  state_t            next_state;
  logic [7:0]        a0;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        cnt_lo;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bidx;
  logic [23:0]       asm_word;
  logic [7:0]        csum;
  logic [TW-1:0]     tcnt;

  logic              accept;
  logic [15:0]       n_full;
  logic [16:0]       end_sum;
  logic              range_bad;
  logic              timed_out;
  logic              resp_ok;
  logic [1:0]        resp_code;

  assign accept  = rx_valid && rx_ready;
  assign n_full  = {rx_data, cnt_lo};
  // 17-bit sum so that start + N == DEPTH is representable and legal.
  assign end_sum   = 17'(start_addr) + {1'b0, n_full};
  assign range_bad = (end_sum > DEPTH_X) || ({1'b0, n_full} > DEPTH_X);
  // tcnt counts idle cycles already seen; this cycle is the TIMEOUT_CYCLES-th.
  assign timed_out = (TIMEOUT_CYCLES != 0) && !accept && (tcnt == T_LAST);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    resp_ok    = 1'b0;
    resp_code  = 2'b00;
    case (state)
      IDLE: begin
        if (accept) next_state = HDR;
      end
      HDR: begin
        if (timed_out) begin
          next_state = RESP;
          resp_code  = 2'b11;
        end else if (accept && bidx == 2'd2) begin
          if (range_bad) begin
            next_state = RESP;
            resp_code  = 2'b01;
          end else if (n_full == 16'd0) begin
            next_state = CSUM;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (timed_out) begin
          next_state = RESP;
          resp_code  = 2'b11;
        end else if (accept && bidx == 2'd3 && words_left == 16'd1) begin
          next_state = CSUM;
        end
      end
      CSUM: begin
        if (timed_out) begin
          next_state = RESP;
          resp_code  = 2'b11;
        end else if (accept) begin
          next_state = RESP;
          if (rx_data == csum) resp_ok = 1'b1;
          else resp_code = 2'b10;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready    <= 1'b0;
      wea         <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      load_active <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= 2'b00;
      a0          <= '0;
      start_addr  <= '0;
      cnt_lo      <= '0;
      words_left  <= '0;
      addr        <= '0;
      bidx        <= '0;
      asm_word    <= '0;
      csum        <= '0;
      tcnt        <= '0;
    end else begin
      wea         <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      // Registered so that RESP drops ready and active in its own cycle.
      rx_ready    <= (next_state != RESP);
      load_active <= (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);

      if ((state == HDR || state == DATA || state == CSUM) && !accept)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;

      case (state)
        IDLE: begin
          if (accept) begin
            a0       <= rx_data;
            err_code <= 2'b00;
            bidx     <= 2'd0;
            csum     <= 8'd0;
          end
        end
        HDR: begin
          if (accept) begin
            case (bidx)
              2'd0:    start_addr <= ADDR_W'({rx_data, a0});
              2'd1:    cnt_lo     <= rx_data;
              default: begin
                words_left <= n_full;
                addr       <= start_addr;
              end
            endcase
            bidx <= (bidx == 2'd2) ? 2'd0 : bidx + 2'd1;
          end
        end
        DATA: begin
          if (accept) begin
            asm_word <= {rx_data, asm_word[23:8]};
            csum     <= csum + rx_data;
            bidx     <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              wea        <= 1'b1;
              addra      <= addr;
              dina       <= {rx_data, asm_word};
              // Wraps only after the final word of an end-of-memory frame,
              // where it is never used again.
              addr       <= addr + ADDR_W'(1);
              words_left <= words_left - 16'd1;
            end
          end
        end
        default: begin
        end
      endcase

      if (next_state == RESP) begin
        load_done <= resp_ok;
        load_err  <= !resp_ok;
        if (!resp_ok) err_code <= resp_code;
      end
    end
  end

endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
// Self-checking bench for ama_riscv_imem_loader: directed frames from the
// test plan plus randomized frames, checked against a frame-level model that
// predicts IMEM writes and the frame outcome.
module tb_ama_riscv_imem_loader;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TO     = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              load_active;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [2:0]        dbg_state;

  ama_riscv_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wea(wea), .addra(addra), .dina(dina),
    .load_active(load_active), .load_done(load_done), .load_err(load_err),
    .err_code(err_code), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [45:0] exp_q[$];   // {addr, data} of expected IMEM writes
  logic [3:0]  resp_q[$];  // {load_done, load_err, err_code} seen per response
  logic [45:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (wea) begin
        if (exp_q.size() == 0) begin
          check("unexp_wea", 64'(wea), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(addra), 64'(mon_e[45:32]));
          check("wr_data", 64'(dina), 64'(mon_e[31:0]));
        end
      end
      if (load_done || load_err) begin
        resp_q.push_back({load_done, load_err, err_code});
        check("resp_active", 64'(load_active), 64'd0);
        check("resp_ready", 64'(rx_ready), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  int gap_max = 0;
  logic [31:0] words[$];

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic [3:0] exp, input string tag, output int lat);
    int n;
    n = 0;
    while (resp_q.size() == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    lat = n;
    if (resp_q.size() == 0) begin
      check({tag, "_noresp"}, 64'(resp_q.size()), 64'd1);
    end else begin
      check(tag, 64'(resp_q.pop_front()), 64'(exp));
      check({tag, "_wr_drain"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      #1;
      check({tag, "_idle_ready"}, 64'(rx_ready), 64'd1);
      check({tag, "_idle_inact"}, 64'(load_active), 64'd0);
      check({tag, "_err_hold"}, 64'(err_code), 64'(exp[1:0]));
    end
  endtask

  // Frame-level model: predicts writes and outcome from header and words.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] n, input int bad_cs, input string tag);
    int          start;
    int          lat;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [3:0]  exp_resp;
    start = a % DEPTH;
    send_byte(a[7:0]);
    check({tag, "_a0_clr"}, 64'(err_code), 64'd0);
    check({tag, "_a0_act"}, 64'(load_active), 64'd1);
    send_byte(a[15:8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (int'(n) > DEPTH || start + int'(n) > DEPTH) begin
      exp_resp = 4'b0101;
    end else begin
      cs = 8'd0;
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        exp_q.push_back({14'(start + i), w});
        for (int k = 0; k < 4; k++) begin
          cs = cs + w[8*k +: 8];
          send_byte(w[8*k +: 8]);
        end
      end
      send_byte(cs + 8'(bad_cs));
      exp_resp = (bad_cs != 0) ? 4'b0110 : 4'b1000;
    end
    wait_resp(exp_resp, tag, lat);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  logic [15:0] ra;
  logic [15:0] rn;

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(rx_ready), 64'd0);
    check("rst_outs", 64'({wea, load_active, load_done, load_err, err_code}), 64'd0);
    check("rst_port", 64'({addra, dina}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reference frame and its bad-checksum twin.
    words = '{32'h00000013, 32'hDEADBEEF};
    run_frame(16'h0010, 16'd2, 0, "ref_ok");
    run_frame(16'h0010, 16'd2, 1, "ref_bad_cs");

    // Range boundary at the top of memory.
    run_frame(16'h3FFF, 16'd2, 0, "range_over");
    words = '{32'hCAFEF00D};
    run_frame(16'h3FFF, 16'd1, 0, "range_edge");

    // Empty frames.
    run_frame(16'h0000, 16'd0, 0, "empty_ok");
    run_frame(16'h0000, 16'd0, 1, "empty_bad");

    // Timeout: N=1, two data bytes, then silence.
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_resp(4'b0111, "timeout", lat);
    check("timeout_lat_ok", 64'(lat >= TO && lat <= TO + 2), 64'd1);
    words = '{32'h01234567, 32'h89ABCDEF};
    run_frame(16'h0020, 16'd2, 0, "after_to");

    // Reset in the middle of DATA, right as a write pulse is out.
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    @(negedge clk);
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_wea", 64'(wea), 64'd1);
    check("pre_rst_dina", 64'(dina), 64'h11223344);
    rst = 1'b1;
    #1;
    check("mid_rst_wea", 64'(wea), 64'd0);
    check("mid_rst_ready", 64'(rx_ready), 64'd0);
    check("mid_rst_active", 64'(load_active), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    check("mid_rst_queues", 64'(resp_q.size() + exp_q.size()), 64'd0);
    rst = 1'b0;
    words = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0BAD_F00D};
    run_frame(16'h0100, 16'd3, 0, "after_rst");

    // Randomized frames with random inter-byte gaps below the timeout.
    gap_max = 3;
    for (int f = 0; f < 24; f++) begin
      ra = 16'($urandom_range(16'hFFFF, 0));
      rn = 16'($urandom_range(6, 1));
      case ($urandom_range(5, 0))
        0: rn = 16'($urandom_range(16'hFFFF, 0));
        1: ra = {2'($urandom_range(3, 0)), 14'h3FFC};
        default: ;
      endcase
      words.delete();
      for (int i = 0; i < 6; i++) words.push_back($urandom);
      run_frame(ra, rn, ($urandom_range(3, 0) == 0) ? 1 : 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
